// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_pkg;

  localparam int unsigned AES_NR          = 10;
  localparam int unsigned AES_NB          = 4;
  localparam int unsigned AES_KEY_TIMEOUT = 15;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    SUB   = 3'd1,
    SHIFT = 3'd2,
    MIX   = 3'd3,
    ARK   = 3'd4
  } stage_sel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARK,
    S_SUB,
    S_SHIFT,
    S_MIX,
    S_DONE
  } ctrl_state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter and key-stall timeout counter for the AES round sequencer.
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int unsigned NR          = AES_NR,
  parameter int unsigned KEY_TIMEOUT = AES_KEY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       tick_wait,
  output logic [3:0] round_num,
  output logic       at_last,
  output logic       timeout
);

  localparam int unsigned     WW           = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
  localparam logic [3:0]      LP_NR        = 4'(NR);
  localparam logic [WW-1:0]   LP_WAIT_LAST = WW'(KEY_TIMEOUT - 1);

  logic [3:0]    r_round;
  logic [WW-1:0] r_wait;

  // The wait count clears on any non-stall cycle, which covers leaving ARK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round <= '0;
      r_wait  <= '0;
    end else if (clr) begin
      r_round <= '0;
      r_wait  <= '0;
    end else begin
      if (inc && !at_last) r_round <= r_round + 4'd1;
      r_wait <= tick_wait ? r_wait + WW'(1) : '0;
    end
  end

  assign round_num = r_round;
  assign at_last   = (r_round == LP_NR);
  // Asserted while the count shows KEY_TIMEOUT-1 prior stalls: this stall is the last allowed.
  assign timeout   = (r_wait == LP_WAIT_LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencing FSM for the AES-128 datapath: stage selects, state write enable, key requests.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR          = AES_NR,
  parameter int unsigned KEY_TIMEOUT = AES_KEY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       key_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [2:0] stage_sel,
  output logic       state_we,
  output logic [3:0] round_num,
  output logic       key_req,
  output logic       done,
  output logic       err
);

  if (NR < 1 || NR > 15) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be in 1..15");
  end
  if (KEY_TIMEOUT < 1) begin : g_bad_timeout
    $error("aes_round_ctrl: KEY_TIMEOUT must be at least 1");
  end

  ctrl_state_t r_state;
  stage_sel_t  w_stage;
  logic        w_abort, w_key_ok, w_stall, w_inc, w_clr;
  logic        w_at_last, w_timeout;
  logic [3:0]  w_round;

  assign w_abort  = abort && (r_state != S_IDLE);
  assign w_key_ok = (r_state == S_ARK) && key_valid && !w_abort;
  assign w_stall  = (r_state == S_ARK) && !key_valid && !w_abort;
  assign w_inc    = w_key_ok && !w_at_last;
  assign w_clr    = w_abort || (w_stall && w_timeout) || (r_state == S_DONE);

  aes_round_counter #(
    .NR          (NR),
    .KEY_TIMEOUT (KEY_TIMEOUT)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .inc       (w_inc),
    .tick_wait (w_stall),
    .round_num (w_round),
    .at_last   (w_at_last),
    .timeout   (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (w_abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_LOAD;
        S_LOAD:  r_state <= S_ARK;
        S_ARK: begin
          if (key_valid)      r_state <= w_at_last ? S_DONE : S_SUB;
          else if (w_timeout) r_state <= S_IDLE;
        end
        S_SUB:   r_state <= S_SHIFT;
        S_SHIFT: r_state <= w_at_last ? S_ARK : S_MIX;
        S_MIX:   r_state <= S_ARK;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stage = LOAD;
    case (r_state)
      S_SUB:   w_stage = SUB;
      S_SHIFT: w_stage = SHIFT;
      S_MIX:   w_stage = MIX;
      S_ARK:   w_stage = ARK;
      default: w_stage = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    stage_sel = w_stage;
    round_num = w_round;
    key_req   = (r_state == S_ARK);
    done      = (r_state == S_DONE) && !w_abort;
    err       = w_stall && w_timeout;
    state_we  = 1'b0;
    case (r_state)
      S_LOAD, S_SUB, S_SHIFT, S_MIX: state_we = !w_abort;
      S_ARK:                         state_we = w_key_ok;
      default:                       state_we = 1'b0;
    endcase
  end

endmodule
